// File: rtl/memory_stage.sv
// memory_stage: pipeline memory stage of a 32-bit RISC-V core.
//
// Takes one instruction at a time from execute, performs the data-memory
// access for loads and stores, forms the writeback result, reports
// JAL/JALR/branch redirects to fetch and forwards the result to execute.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   IR, ALU, PC, B      instruction, ALU result, PC and rs2 value from execute
//   COMP                branch-compare result from execute
//   v_in / r_out        upstream valid / ready
//   v_out / r_in        downstream valid / ready
//   IR_out, MEM_out     instruction and writeback result of the held entry
//   FM, AM              forwarded value and its destination register (0 = none)
//   br_taken, br_target one-cycle redirect pulse and its target
//   dm_*                data-memory request/response port
//   misalign            held entry was a misaligned access (checked builds only)
//
// Parameters
//   XLEN    datapath width; only 32 is supported
//   RST_PC  value driven on br_target while in reset
//
// Build option
//   MEMORY_STAGE_MISALIGN_CHECK_EN  when defined, misaligned LH/LHU/SH/LW/SW
//   are not issued to memory; they complete at once with misalign=1.
//   When undefined, misalign is tied low and every access is issued.

module memory_stage #(
  parameter int unsigned XLEN   = 32,
  parameter logic [31:0] RST_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] IR,
  input  logic [XLEN-1:0] ALU,
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] B,
  input  logic            COMP,
  input  logic            v_in,
  output logic            r_out,
  output logic            v_out,
  input  logic            r_in,
  output logic [XLEN-1:0] IR_out,
  output logic [XLEN-1:0] MEM_out,
  output logic [XLEN-1:0] FM,
  output logic [4:0]      AM,
  output logic            br_taken,
  output logic [XLEN-1:0] br_target,
  output logic            dm_req,
  output logic            dm_we,
  output logic [XLEN-1:0] dm_addr,
  output logic [XLEN-1:0] dm_wdata,
  output logic [3:0]      dm_be,
  input  logic            dm_ack,
  input  logic [XLEN-1:0] dm_rdata,
  output logic            misalign
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    FULL
  } state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] alu_q, alu_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] br_target_q, br_target_d;
  logic            br_taken_q, br_taken_d;

  logic            accept;
  logic [6:0]      in_op;
  logic            in_is_mem;
  logic            acc_mis;
  logic            mis_hold;
  state_e          in_target;

  logic [6:0]      op_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic            is_load_q;
  logic            is_store_q;
  logic            writes_rd_q;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;

  // ---------------------------------------------------------------------
  // Decode of the instruction being offered by execute
  // ---------------------------------------------------------------------
  assign in_op     = IR[6:0];
  assign in_is_mem = (in_op == OP_LOAD) || (in_op == OP_STORE);

`ifdef MEMORY_STAGE_MISALIGN_CHECK_EN
  logic mis_q;

  // funct3[1:0] gives the access size for both loads and stores:
  // 00 byte, 01 halfword, 10 word.
  always_comb begin
    acc_mis = 1'b0;
    if (in_is_mem) begin
      unique case (IR[13:12])
        2'b01:   acc_mis = ALU[0];
        2'b10:   acc_mis = |ALU[1:0];
        default: acc_mis = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else if (accept) begin
      mis_q <= acc_mis;
    end
  end

  assign mis_hold = mis_q;
`else
  assign acc_mis  = 1'b0;
  assign mis_hold = 1'b0;
`endif

  // A misaligned access (checked builds) completes without touching memory.
  assign in_target = (in_is_mem && !acc_mis) ? ACCESS : FULL;

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    r_out = 1'b0;
    unique case (state_q)
      IDLE:    r_out = 1'b1;
      ACCESS:  r_out = 1'b0;
      FULL:    r_out = r_in;
      default: r_out = 1'b0;
    endcase
  end

  assign accept = v_in && r_out;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = in_target;
      end
      ACCESS: begin
        if (dm_ack) state_d = FULL;
      end
      FULL: begin
        // Draining and refilling in the same cycle keeps the stage busy.
        if (accept)    state_d = in_target;
        else if (r_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Held-instruction decode
  // ---------------------------------------------------------------------
  assign op_q        = ir_q[6:0];
  assign f3_q        = ir_q[14:12];
  assign off_q       = alu_q[1:0];
  assign is_load_q   = (op_q == OP_LOAD);
  assign is_store_q  = (op_q == OP_STORE);
  assign writes_rd_q = (op_q != OP_BRANCH) && (op_q != OP_STORE);

  // ---------------------------------------------------------------------
  // Load lane extraction
  // ---------------------------------------------------------------------
  always_comb begin
    ld_byte = dm_rdata[7:0];
    unique case (off_q)
      2'd0:    ld_byte = dm_rdata[7:0];
      2'd1:    ld_byte = dm_rdata[15:8];
      2'd2:    ld_byte = dm_rdata[23:16];
      default: ld_byte = dm_rdata[31:24];
    endcase
  end

  // Halfword lane follows the same addr[1] selection the store side uses.
  assign ld_half = off_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];

  always_comb begin
    ld_data = dm_rdata;
    unique case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = dm_rdata;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_comb begin
    ir_d        = ir_q;
    alu_d       = alu_q;
    b_d         = b_q;
    result_d    = result_q;
    br_target_d = br_target_q;
    br_taken_d  = 1'b0;

    if (accept) begin
      ir_d  = IR;
      alu_d = ALU;
      b_d   = B;

      unique case (in_op)
        OP_LOAD, OP_STORE, OP_BRANCH: result_d = '0;
        OP_JAL, OP_JALR:              result_d = PC + XLEN'(4);
        default:                      result_d = ALU;
      endcase

      br_target_d = (in_op == OP_JALR) ? {ALU[XLEN-1:1], 1'b0} : ALU;

      unique case (in_op)
        OP_BRANCH:       br_taken_d = COMP;
        OP_JAL, OP_JALR: br_taken_d = 1'b1;
        default:         br_taken_d = 1'b0;
      endcase
    end else if ((state_q == ACCESS) && dm_ack && is_load_q) begin
      result_d = ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q        <= '0;
      alu_q       <= '0;
      b_q         <= '0;
      result_q    <= '0;
      br_target_q <= RST_PC;
      br_taken_q  <= 1'b0;
    end else begin
      ir_q        <= ir_d;
      alu_q       <= alu_d;
      b_q         <= b_d;
      result_q    <= result_d;
      br_target_q <= br_target_d;
      br_taken_q  <= br_taken_d;
    end
  end

  // ---------------------------------------------------------------------
  // Data-memory port
  // ---------------------------------------------------------------------
  assign dm_req  = (state_q == ACCESS);
  assign dm_we   = dm_req && is_store_q;
  assign dm_addr = alu_q;

  always_comb begin
    dm_be    = '0;
    dm_wdata = '0;
    if (dm_we) begin
      unique case (f3_q)
        3'b000: begin
          dm_be    = 4'b0001 << off_q;
          dm_wdata = {4{b_q[7:0]}};
        end
        3'b001: begin
          dm_be    = off_q[1] ? 4'b1100 : 4'b0011;
          dm_wdata = {2{b_q[15:0]}};
        end
        default: begin
          dm_be    = '1;
          dm_wdata = b_q;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Result, forwarding and redirect outputs
  // ---------------------------------------------------------------------
  assign v_out     = (state_q == FULL);
  assign IR_out    = ir_q;
  assign MEM_out   = result_q;
  assign FM        = result_q;
  assign AM        = (v_out && writes_rd_q && !mis_hold) ? ir_q[11:7] : '0;
  assign br_taken  = br_taken_q;
  assign br_target = br_target_q;
  assign misalign  = v_out && mis_hold;

endmodule
